input_debouncer: RTL and testbench

//   Cleans raw board inputs (direction push-button, speed DIP switches) before they reach

---
 rtl/input_debouncer.sv | 100 ++++++++++
 tb/tb_input_debouncer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchronizer, stability counter, registered
// debounced level and single-cycle rise/fall pulses for bouncing board inputs.
//
// Each channel's state is carried by its counter alone:
//   STABLE   : synchronized value equals o_level, counter held at 0
//   COUNTING : values differ, counter advances once per cycle
//   COMMIT   : values differ and the counter has reached DEBOUNCE_CYCLES-1;
//              o_level takes the synchronized value and one pulse is emitted
// o_busy exposes STABLE versus COUNTING/COMMIT for every channel.
module input_debouncer #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_busy
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  // Synchronizer chain: stage 0 samples the raw pins, last stage is s.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw inputs through the synchronizer chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {WIDTH{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= i_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Per-channel next state: count disagreement, commit on the last count,
  // clear the counter whenever the synchronized value agrees again.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_d[k] = '0;
      if (sync_s[k] != level_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          level_d[k] = sync_s[k];
          rise_d[k]  = sync_s[k];
          fall_d[k]  = ~sync_s[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  // Register level, pulses and counters; reset discards any progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q <= {WIDTH{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  // Busy is combinational so it shows the very cycle a disagreement appears.
  assign o_busy  = sync_s ^ level_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with WIDTH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, RESET_LEVEL=0: a step on i_raw shows on o_level and
// the matching pulse exactly 10 edges after the change.
module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] busy;

  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_raw  (raw),
    .o_level(level),
    .o_rise (rise),
    .o_fall (fall),
    .o_busy (busy)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n edges on which no pulse of either kind may appear.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_rise"}, rise, 2'b00);
      check({tag, "_fall"}, fall, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b1;
    raw = 2'b11;

    // Reset held 3 cycles with inputs high: everything stays at 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_level", level, 2'b00);
      check("rst_rise",  rise,  2'b00);
      check("rst_fall",  fall,  2'b00);
      check("rst_busy",  busy,  2'b00);
    end
    rst = 1'b0;

    // After release both channels qualify and rise on edge 10.
    tick();
    check("post_rst_busy1", busy, 2'b00);
    check("post_rst_rise1", rise, 2'b00);
    tick();
    check("post_rst_busy2", busy, 2'b11);
    check("post_rst_rise2", rise, 2'b00);
    quiet(7, "post_rst_wait");
    check("post_rst_level9", level, 2'b00);
    tick();
    check("post_rst_rise10",  rise,  2'b11);
    check("post_rst_level10", level, 2'b11);
    check("post_rst_fall10",  fall,  2'b00);
    check("post_rst_busy10",  busy,  2'b00);
    tick();
    check("post_rst_rise_end", rise, 2'b00);

    // Bring both back low: fall on edge 10.
    raw = 2'b00;
    quiet(9, "both_low_wait");
    tick();
    check("both_low_fall",  fall,  2'b11);
    check("both_low_level", level, 2'b00);
    tick();
    check("both_low_fall_end", fall, 2'b00);

    // Clean step on channel 0.
    raw = 2'b01;
    tick();
    check("step_busy1", busy, 2'b00);
    tick();
    check("step_busy2", busy, 2'b01);
    quiet(7, "step_wait");
    check("step_level9", level, 2'b00);
    tick();
    check("step_rise10",  rise,  2'b01);
    check("step_level10", level, 2'b01);
    tick();
    check("step_rise_end", rise, 2'b00);

    raw = 2'b00;
    quiet(9, "step_down_wait");
    tick();
    check("step_down_fall",  fall,  2'b01);
    check("step_down_level", level, 2'b00);
    tick();
    check("step_down_fall_end", fall, 2'b00);

    // Bounce on channel 0: 1,0,1,0 for 3 cycles each, then held 1.
    raw = 2'b01; quiet(3, "bounce_a");
    raw = 2'b00; quiet(3, "bounce_b");
    raw = 2'b01; quiet(3, "bounce_c");
    raw = 2'b00; quiet(3, "bounce_d");
    check("bounce_level", level, 2'b00);
    raw = 2'b01;
    quiet(9, "bounce_settle");
    tick();
    check("bounce_rise",  rise,  2'b01);
    check("bounce_level_end", level, 2'b01);
    tick();
    check("bounce_rise_end", rise, 2'b00);

    // Glitch on channel 1: 7 cycles high is one short of qualifying.
    raw = 2'b11;
    quiet(7, "glitch_hi");
    raw = 2'b01;
    quiet(3, "glitch_lo");
    check("glitch_level", level, 2'b01);
    check("glitch_busy",  busy,  2'b00);

    // Counter must have cleared: a new step takes the full 10 edges.
    raw = 2'b11;
    quiet(9, "requal_wait");
    check("requal_level9", level, 2'b01);
    tick();
    check("requal_rise",  rise,  2'b10);
    check("requal_level", level, 2'b11);

    // Simultaneous steps on both channels.
    raw = 2'b00;
    quiet(9, "simul_fall_wait");
    tick();
    check("simul_fall",       fall,  2'b11);
    check("simul_fall_level", level, 2'b00);
    raw = 2'b11;
    quiet(9, "simul_rise_wait");
    tick();
    check("simul_rise",       rise,  2'b11);
    check("simul_rise_level", level, 2'b11);

    // Channel 1 bounces while channel 0 holds steady.
    raw = 2'b01; quiet(2, "indep_a");
    raw = 2'b11; quiet(2, "indep_b");
    raw = 2'b01; quiet(2, "indep_c");
    raw = 2'b11; quiet(4, "indep_d");
    check("indep_level", level, 2'b11);
    check("indep_busy",  busy,  2'b00);

    // Return to idle low.
    raw = 2'b00;
    quiet(9, "idle_wait");
    tick();
    check("idle_fall", fall, 2'b11);
    tick();

    // Reset mid-count: step channel 0, reset when the counter reaches 5.
    raw = 2'b01;
    quiet(7, "midrst_count");
    check("midrst_busy", busy, 2'b01);
    rst = 1'b1;
    tick();
    check("midrst_level", level, 2'b00);
    check("midrst_rise",  rise,  2'b00);
    check("midrst_busy0", busy,  2'b00);
    rst = 1'b0;
    tick();
    check("midrst_rel_busy", busy, 2'b00);
    check("midrst_rel_rise", rise, 2'b00);
    quiet(8, "midrst_requal");
    check("midrst_level9", level, 2'b00);
    tick();
    check("midrst_rise10",  rise,  2'b01);
    check("midrst_level10", level, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
